// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the set-array SRAM initiator.
package sram_ctrl_pkg;
  localparam int SETS_DFLT  = 512;
  localparam int WAYS_DFLT  = 4;
  localparam int WAY_W_DFLT = 19;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // Low bit of way i inside a WAYS*WAY_W data word.
  function automatic int way_slice(input int i);
    return i * WAY_W_DFLT;
  endfunction
endpackage

// File: rtl/sram_resp_skid.sv
// One-entry response skid absorbing the fixed 1-cycle SRAM read latency.
// Optional macro SRAM_RDATA_HOLD_EN keeps the last delivered data on resp_rdata when idle.
module sram_resp_skid #(
  parameter int DW = 76
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_fire,
  input  logic          resp_ready,
  input  logic [DW-1:0] sram_rdata,
  output logic          buf_valid,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata
);
  logic          rd_pend_q, rd_pend_d;
  logic          buf_valid_q, buf_valid_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [DW-1:0] mux_data;

  always_comb begin
    rd_pend_d   = rd_pend_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (buf_valid_q) begin
      // No read can fire while buffered, so a pending result stays put in the SRAM.
      if (resp_ready) buf_valid_d = 1'b0;
    end else begin
      rd_pend_d = rd_fire;
      if (rd_pend_q && !resp_ready) begin
        buf_valid_d = 1'b1;
        buf_d       = sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_ff @(posedge clk) buf_q <= buf_d;

  assign buf_valid  = buf_valid_q;
  assign resp_valid = buf_valid_q | rd_pend_q;
  assign mux_data   = buf_valid_q ? buf_q : sram_rdata;

`ifdef SRAM_RDATA_HOLD_EN
  logic [DW-1:0] last_q;
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= '0;
    else if (resp_valid && resp_ready) last_q <= mux_data;
  end
  assign resp_rdata = resp_valid ? mux_data : last_q;
`else
  assign resp_rdata = resp_valid ? mux_data : '0;
`endif
endmodule

// File: rtl/sram_array_ctrl.sv
// RW0 initiator for the way-masked set-array SRAM: clear sweep after reset, then request issue.
// Optional macro SRAM_RDATA_HOLD_EN (handled in sram_resp_skid) holds idle resp_rdata.
module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int  SETS   = SETS_DFLT,
  parameter int  ADDR_W = $clog2(SETS),
  parameter int  WAYS   = WAYS_DFLT,
  parameter int  WAY_W  = WAY_W_DFLT,
  localparam int DW     = WAYS * WAY_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [WAYS-1:0]   req_waymask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DW-1:0]     resp_rdata,
  output logic              init_done,
  output logic              RW0_clk,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DW-1:0]     RW0_wdata,
  output logic [WAYS-1:0]   RW0_wmask,
  input  logic [DW-1:0]     RW0_rdata
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              buf_valid;
  logic              fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(SETS - 1)) state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_done = (state_q == IDLE);
  assign req_ready = init_done && !buf_valid;
  assign fire      = req_valid && req_ready;
  assign RW0_clk   = clock;

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    RW0_wmask = '0;
    if (state_q == INIT) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = cnt_q;
      RW0_wmask = '1;
    end else if (fire) begin
      RW0_en    = 1'b1;
      RW0_wmode = req_write;
      RW0_addr  = req_addr;
      if (req_write) begin
        RW0_wdata = req_wdata;
        RW0_wmask = req_waymask;
      end
    end
  end

  sram_resp_skid #(.DW(DW)) u_skid (
    .clk        (clock),
    .rst_n      (reset_n),
    .rd_fire    (fire && !req_write),
    .resp_ready (resp_ready),
    .sram_rdata (RW0_rdata),
    .buf_valid  (buf_valid),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );
endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: SRAM behavioural model, queue-based reference, vector table and corner sequences.
module tb_sram_array_ctrl;
  import sram_ctrl_pkg::*;
  localparam int SETS = 512, AW = 9, WAYS = 4, WW = 19, DW = 76;

  logic clock = 1'b0;
  logic reset_n, req_valid, req_write, resp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [WAYS-1:0] req_waymask;
  logic req_ready, resp_valid, init_done;
  logic [DW-1:0] resp_rdata;
  logic RW0_clk, RW0_en, RW0_wmode;
  logic [AW-1:0] RW0_addr;
  logic [DW-1:0] RW0_wdata, RW0_rdata;
  logic [WAYS-1:0] RW0_wmask;

  always #5 clock = ~clock;

  sram_array_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_waymask(req_waymask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done), .RW0_clk(RW0_clk), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
  );

  // SRAM: 1-cycle read latency, output held while not reading.
  logic [DW-1:0] mem [SETS];
  logic [DW-1:0] sram_q = '0;
  assign RW0_rdata = sram_q;
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int i = 0; i < WAYS; i++)
          if (RW0_wmask[i]) mem[RW0_addr][way_slice(i) +: WW] <= RW0_wdata[way_slice(i) +: WW];
      end else sram_q <= mem[RW0_addr];
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  // Reference: golden contents, in-order queue of owed read data, head-refused flag.
  logic [DW-1:0] gold [SETS];
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_last = '0;
  bit m_known = 0, m_idle = 0, m_refused = 0, m_fire = 0;
  int m_cnt = 0;

  always @(negedge clock) begin
    if (m_known) begin
      chk("init_done", 128'(init_done), 128'(m_idle));
      chk("rw0_clk", 128'(RW0_clk), 128'(0));
      if (!m_idle) begin
        m_fire = 0;
        chk("sweep_en", 128'(RW0_en), 128'(1));
        chk("sweep_wmode", 128'(RW0_wmode), 128'(1));
        chk("sweep_addr", 128'(RW0_addr), 128'(m_cnt));
        chk("sweep_wdata", 128'(RW0_wdata), 128'(0));
        chk("sweep_wmask", 128'(RW0_wmask), 128'(4'hF));
        chk("sweep_ready", 128'(req_ready), 128'(0));
        chk("sweep_rvalid", 128'(resp_valid), 128'(0));
      end else begin
        m_fire = req_valid && !m_refused;
        chk("req_ready", 128'(req_ready), 128'(!m_refused));
        chk("rw_en", 128'(RW0_en), 128'(m_fire));
        chk("rw_wmode", 128'(RW0_wmode), 128'(m_fire && req_write));
        chk("rw_wmask", 128'(RW0_wmask), 128'((m_fire && req_write) ? req_waymask : 4'h0));
        if (m_fire) chk("rw_addr", 128'(RW0_addr), 128'(req_addr));
        if (m_fire && req_write) chk("rw_wdata", 128'(RW0_wdata), 128'(req_wdata));
        chk("resp_valid", 128'(resp_valid), 128'(q.size() != 0));
        if (q.size() != 0) chk("resp_rdata", 128'(resp_rdata), 128'(q[0]));
`ifdef SRAM_RDATA_HOLD_EN
        else chk("idle_rdata", 128'(resp_rdata), 128'(m_last));
`else
        else chk("idle_rdata", 128'(resp_rdata), 128'(0));
`endif
      end
    end
    if (!reset_n) begin
      m_known = 1; m_idle = 0; m_cnt = 0; m_refused = 0; m_last = '0;
      q.delete();
    end else if (m_known) begin
      if (!m_idle) begin
        gold[m_cnt] = '0;
        if (m_cnt == SETS - 1) begin m_idle = 1; m_cnt = 0; end
        else m_cnt++;
      end else begin
        if (q.size() != 0) begin
          if (resp_ready) begin m_last = q.pop_front(); m_refused = 0; end
          else m_refused = 1;
        end
        if (m_fire) begin
          if (req_write) begin
            for (int i = 0; i < WAYS; i++)
              if (req_waymask[i]) gold[req_addr][way_slice(i) +: WW] = req_wdata[way_slice(i) +: WW];
          end else q.push_back(gold[req_addr]);
        end
      end
    end
  end

  typedef struct {
    logic v, w; logic [AW-1:0] a; logic [DW-1:0] d; logic [WAYS-1:0] m; logic rr;
    logic e_ready, e_en, e_rv; logic [DW-1:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic v, w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [WAYS-1:0] m, input logic rr, e_ready, e_en, e_rv,
                              input logic [DW-1:0] e_rd);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.m = m; t.rr = rr;
    t.e_ready = e_ready; t.e_en = e_en; t.e_rv = e_rv; t.e_rd = e_rd;
    return t;
  endfunction

  task automatic drive(input logic v, w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [WAYS-1:0] m, input logic rr);
    @(posedge clock); #1;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_waymask = m; resp_ready = rr;
  endtask

  vec_t tv [9];
  logic [DW-1:0] w2, w03, p1, p2, hold_exp;
  logic [95:0] r96;

  initial begin
    w2  = 76'h7FFFF << 38;
    w03 = (76'h7FFFF << 57) | 76'h7FFFF;
    p1  = 76'h2_468A_CE13_579B_DF02_46;
    p2  = ~p1;
    tv[0] = mk(1, 1, 5, w2, 4'b0100, 1, 1, 1, 0, '0);
    tv[1] = mk(1, 1, 6, '1, 4'b1001, 1, 1, 1, 0, '0);
    tv[2] = mk(1, 0, 5, '0, 4'h0, 1, 1, 1, 0, '0);
    tv[3] = mk(1, 0, 6, '0, 4'h0, 1, 1, 1, 1, w2);
    tv[4] = mk(1, 0, 1, '0, 4'h0, 1, 1, 1, 1, w03);
    tv[5] = mk(1, 0, 2, '0, 4'h0, 1, 1, 1, 1, '0);
    tv[6] = mk(1, 0, 3, '0, 4'h0, 1, 1, 1, 1, '0);
    tv[7] = mk(0, 0, 0, '0, 4'h0, 1, 1, 0, 1, '0);
    tv[8] = mk(0, 0, 0, '0, 4'h0, 1, 1, 0, 0, '0);

    reset_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_waymask = '0; resp_ready = 1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;

    // Clear sweep: SETS cycles, init_done one cycle after the last write.
    repeat (511) @(posedge clock);
    @(negedge clock) chk("init_done_at_511", 128'(init_done), 128'(0));
    @(posedge clock);
    @(negedge clock) chk("init_done_at_512", 128'(init_done), 128'(1));

    for (int i = 0; i < 9; i++) begin
      drive(tv[i].v, tv[i].w, tv[i].a, tv[i].d, tv[i].m, tv[i].rr);
      @(negedge clock);
      chk($sformatf("tv%0d_ready", i), 128'(req_ready), 128'(tv[i].e_ready));
      chk($sformatf("tv%0d_en", i), 128'(RW0_en), 128'(tv[i].e_en));
      chk($sformatf("tv%0d_rvalid", i), 128'(resp_valid), 128'(tv[i].e_rv));
      chk($sformatf("tv%0d_rdata", i), 128'(resp_rdata), 128'(tv[i].e_rd));
    end

    // Idle after a read: held data or zero depending on build.
    drive(1, 1, 9, p1, 4'hF, 1);
    drive(1, 0, 9, '0, 4'h0, 1);
    drive(0, 0, 0, '0, 4'h0, 1);
    @(negedge clock) chk("hold_rv", 128'(resp_rdata), 128'(p1));
    drive(0, 0, 0, '0, 4'h0, 1);
`ifdef SRAM_RDATA_HOLD_EN
    hold_exp = p1;
`else
    hold_exp = '0;
`endif
    @(negedge clock) chk("hold_idle", 128'(resp_rdata), 128'(hold_exp));

    // Stalled consumer: skid fills, req_ready drops, order and data preserved.
    drive(1, 1, 7, p2, 4'hF, 1);
    drive(1, 0, 7, '0, 4'h0, 0);
    @(negedge clock) chk("stall_a_ready", 128'(req_ready), 128'(1));
    drive(1, 0, 5, '0, 4'h0, 0);
    @(negedge clock) chk("stall_b_data", 128'(resp_rdata), 128'(p2));
    drive(0, 0, 0, '0, 4'h0, 0);
    @(negedge clock) chk("stall_c_ready", 128'(req_ready), 128'(0));
    drive(0, 0, 0, '0, 4'h0, 0);
    @(negedge clock) chk("stall_d_data", 128'(resp_rdata), 128'(p2));
    drive(0, 0, 0, '0, 4'h0, 1);
    @(negedge clock) chk("stall_e_data", 128'(resp_rdata), 128'(p2));
    drive(0, 0, 0, '0, 4'h0, 1);
    @(negedge clock) chk("stall_f_data", 128'(resp_rdata), 128'(w2));
    drive(0, 0, 0, '0, 4'h0, 1);
    @(negedge clock) chk("stall_g_rvalid", 128'(resp_valid), 128'(0));

    // Reset with both pending and buffered responses outstanding.
    drive(1, 0, 7, '0, 4'h0, 0);
    drive(1, 0, 5, '0, 4'h0, 0);
    drive(0, 0, 0, '0, 4'h0, 0);
    @(negedge clock) chk("pre_rst_ready", 128'(req_ready), 128'(0));
    reset_n = 0;
    @(posedge clock); #1 reset_n = 1; resp_ready = 1;
    @(negedge clock);
    chk("rst_rvalid", 128'(resp_valid), 128'(0));
    chk("rst_addr", 128'(RW0_addr), 128'(0));
    chk("rst_wmode", 128'(RW0_wmode), 128'(1));
    repeat (512) @(posedge clock);
    @(negedge clock) chk("resweep_done", 128'(init_done), 128'(1));

    // Random traffic on a small address window to force collisions.
    for (int c = 0; c < 1500; c++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      drive(($urandom % 4) != 0, ($urandom % 3) == 0, AW'($urandom % 16), r96[DW-1:0],
            WAYS'($urandom), ($urandom % 10) < 7);
    end
    drive(0, 0, 0, '0, 4'h0, 1);
    repeat (4) @(posedge clock);
    @(negedge clock) chk("drain_rvalid", 128'(resp_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
